// File: rtl/control_sequencer.sv
// Control sequencer for a simple multi-cycle CPU datapath: a 10-state Moore FSM
// that runs fetch (F0-F2), then per-opcode execute steps (T3-T7), with HALT entry
// on a stop request at instruction boundaries or on halt/undefined opcodes.
module control_sequencer (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        Run,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        PCin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  Operator
);

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OPC_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OPC_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OPC_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OPC_NOP  = 5'b11010;

  localparam logic [OP_W-1:0] ALU_ADD = 5'b00011;
  localparam logic [OP_W-1:0] ALU_AND = 5'b00101;
  localparam logic [OP_W-1:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    S_RESET, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [OP_W-1:0] opcode;
  logic            is_ld, is_ldi, is_st, is_alu, is_imm, is_nop;
  logic [OP_W-1:0] imm_op;
  logic            unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // Opcode class decode; anything unlisted (including 11011) falls out as halt
  always_comb begin
    is_ld  = (opcode == OPC_LD);
    is_ldi = (opcode == OPC_LDI);
    is_st  = (opcode == OPC_ST);
    is_alu = (opcode == OPC_ADD) || (opcode == OPC_SUB) ||
             (opcode == OPC_AND) || (opcode == OPC_OR);
    is_imm = (opcode == OPC_ADDI) || (opcode == OPC_ANDI) || (opcode == OPC_ORI);
    is_nop = (opcode == OPC_NOP);
    imm_op = ALU_ADD;
    if (opcode == OPC_ANDI) imm_op = ALU_AND;
    if (opcode == OPC_ORI)  imm_op = ALU_OR;
  end

  // State register; clear forces RESET asynchronously
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Next-state and Moore output decode of state and opcode
  always_comb begin
    state_d  = state_q;
    Run      = 1'b0;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    Cout     = 1'b0;
    BAout    = 1'b0;
    Rout     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    Rin      = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    Operator = '0;

    unique case (state_q)
      S_RESET: state_d = S_F0;
      S_F0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_d = S_F2;
      end
      S_F2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        Run = 1'b1;
        if (is_ld || is_ldi || is_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
          state_d = S_T4;
        end else if (is_alu || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          state_d = S_T4;
        end else if (is_nop) begin
          state_d = stop ? S_HALT : S_F0;
        end else begin
          state_d = S_HALT;
        end
      end
      S_T4: begin
        Run = 1'b1;
        state_d = S_T5;
        if (is_ld || is_ldi || is_st) begin
          Cout = 1'b1; Zin = 1'b1; Operator = ALU_ADD;
        end else if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; Operator = opcode;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1; Operator = imm_op;
        end else begin
          state_d = S_HALT;
        end
      end
      S_T5: begin
        Run = 1'b1;
        Zlowout = 1'b1;
        if (is_ld || is_st) begin
          MARin = 1'b1;
          state_d = S_T6;
        end else if (is_ldi || is_alu || is_imm) begin
          Gra = 1'b1; Rin = 1'b1;
          state_d = stop ? S_HALT : S_F0;
        end else begin
          Zlowout = 1'b0;
          state_d = S_HALT;
        end
      end
      S_T6: begin
        Run = 1'b1;
        state_d = S_T7;
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else begin
          state_d = S_HALT;
        end
      end
      S_T7: begin
        Run = 1'b1;
        state_d = stop ? S_HALT : S_F0;
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end else begin
          state_d = S_HALT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 clear  input  1  reset, asynchronous, active-high; forces RESET state and all outputs 0 immediately.
REQ-003 IR  input  32  current instruction register contents; opcode = IR[31:27].
REQ-004 stop  input  1  halt request, honoured only at instruction boundary.
REQ-005 Run  output  1  1 in all states except RESET and HALT.
REQ-006 PCout, Zlowout, MDRout, Cout, BAout, Rout  output  1 each  bus drive enables.
REQ-007 MARin, MDRin, IRin, Yin, Zin, PCin, Rin  output  1 each  register load enables.
REQ-008 Gra, Grb, Grc  output  1 each  register-field select to datapath select/encode logic.
REQ-009 IncPC, Read, Write  output  1 each  PC increment, memory read, memory write.
REQ-010 Operator  output  5  ALU operation; 00000 when Zin=0.

Function
REQ-011 States SHALL be RESET, F0, F1, F2, T3, T4, T5, T6, T7, HALT; one-hot or binary encoding is free.
REQ-012 Outputs SHALL be Moore-style combinational decode of state and IR[31:27]; any signal not listed for a state is 0.
REQ-013 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, nop 11010, halt 11011; any other value is treated as halt.
REQ-014 Operator codes: ADD 00011, SUB 00100, AND 00101, OR 00110; immediate ops use the matching register-op code (addi->00011, andi->00101, ori->00110).
REQ-015 RESET -> F0 on first rising clk with clear=0.
REQ-016 F0: PCout, MARin, IncPC, Zin -> F1.
REQ-017 F1: Zlowout, PCin, Read, MDRin -> F2.
REQ-018 F2: MDRout, IRin -> T3.
REQ-019 ld: T3 Grb,BAout,Yin; T4 Cout,Operator=ADD,Zin; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
REQ-020 ldi: T3 Grb,BAout,Yin; T4 Cout,Operator=ADD,Zin; T5 Zlowout,Gra,Rin; instruction ends at T5.
REQ-021 st: T3-T5 as ld; T6 Gra,Rout,MDRin (Read=0); T7 Write; instruction ends at T7.
REQ-022 add/sub/and/or: T3 Grb,Rout,Yin; T4 Grc,Rout,Operator,Zin; T5 Zlowout,Gra,Rin; ends at T5.
REQ-023 addi/andi/ori: T3 Grb,Rout,Yin; T4 Cout,Operator,Zin; T5 Zlowout,Gra,Rin; ends at T5.
REQ-024 nop: T3 asserts nothing; ends at T3.
REQ-025 halt/undefined: from T3 go to HALT with no control asserted in T3.
REQ-026 At the last state of an instruction, next state SHALL be HALT if stop=1 at that clock edge, else F0.
REQ-027 stop SHALL be ignored in F0-F2 and in non-final T states; an instruction is never abandoned mid-sequence.
REQ-028 HALT: all outputs 0, Run=0, remains in HALT until clear.
REQ-029 Read and Write SHALL never be asserted in the same state; Gra/Grb/Grc are mutually exclusive.
REQ-030 IR changes outside F2->T3 SHALL not occur in normal use; decode samples IR continuously.
REQ-031 Cycle counts: ld/st 8, ldi/ALU/imm 6, nop 4 clocks per instruction.

Reset
REQ-032 clear=1 at any time, including mid-instruction, SHALL asynchronously force RESET with all outputs and Run = 0 in the same delta.
REQ-033 Deassertion of clear SHALL be synchronous in effect: F0 entered at the first rising clk after clear falls.

Verification
REQ-034 clear pulse, IR=0 -> all outputs 0; next edge F0 with PCout=MARin=IncPC=Zin=1, Run=1.
REQ-035 IR=opcode 00011 (add) -> F0,F1,F2,T3,T4,T5 then F0; T4 shows Grc=Rout=Zin=1, Operator=00011.
REQ-036 IR=ld -> T6 Read=MDRin=1, T7 MDRout=Gra=Rin=1; total 8 clocks back to F0.
REQ-037 IR=st, stop=1 raised during T4 -> st completes with Write=1 in T7, then HALT, Run=0, stays 5 further clocks.
REQ-038 IR=11111 (undefined) -> F0,F1,F2,T3 then HALT; Write and Rin never asserted.
REQ-039 clear asserted during T5 of ldi -> Gra/Rin drop to 0 before next edge; restart at F0.
